// File: rtl/writeback_unit.sv
// Writeback stage: writeback mux, bypassed 4-entry register file,
// OUT-instruction FIFO with ready/valid drain, and retired-instruction counter.
module writeback_unit #(
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned REG_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_regf_W,
  input  logic             mux_out_sel_W,
  input  logic             mux_rdata_sel_W,
  input  logic             out_port_sel_W,
  input  logic [1:0]       ADDER_W,
  input  logic [15:0]      read_data_W,
  input  logic [15:0]      alu_out_W,
  input  logic [7:0]       IN_PORT_W,
  input  logic [15:0]      RD2_W,
  input  logic [1:0]       ra1,
  input  logic [1:0]       ra2,
  output logic [REG_W-1:0] rd1,
  output logic [REG_W-1:0] rd2,
  output logic [15:0]      wb_data_W,
  output logic [7:0]       OUT_PORT,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_full,
  output logic             overflow,
  output logic [15:0]      retired_cnt
);

  localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [REG_W-1:0] regs [4];
  logic [7:0]       mem [OUT_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [REG_W-1:0] wb_reg;
  logic             push;
  logic             pop;
  logic             push_ok;
  logic             unused_rd2_hi;

  // Only the low byte of RD2 feeds the output port
  assign unused_rd2_hi = ^RD2_W[15:8];

  // Writeback source select; input-port data has top priority
  always_comb begin
    wb_data_W = alu_out_W;
    if (mux_rdata_sel_W)
      wb_data_W = {8'h00, IN_PORT_W};
    else if (mux_out_sel_W)
      wb_data_W = read_data_W;
  end

  assign wb_reg = wb_data_W[REG_W-1:0];

  // Read ports with same-cycle write-before-read bypass
  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (wr_en_regf_W && (ADDER_W == ra1))
      rd1 = wb_reg;
    if (wr_en_regf_W && (ADDER_W == ra2))
      rd2 = wb_reg;
  end

  // Register file write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++)
        regs[i] <= '0;
    end else if (wr_en_regf_W) begin
      regs[ADDER_W] <= wb_reg;
    end
  end

  // FIFO status and handshake; a full FIFO still accepts a push when it pops
  assign out_valid = (count != '0);
  assign out_full  = (count == CNT_W'(OUT_DEPTH));
  assign OUT_PORT  = mem[rd_ptr];
  assign push      = out_port_sel_W;
  assign pop       = out_valid && out_ready;
  assign push_ok   = push && ((count < CNT_W'(OUT_DEPTH)) || pop);

  // Output FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < OUT_DEPTH; i++)
        mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= RD2_W[7:0];
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && !push_ok)
        overflow <= 1'b1;
    end
  end

  // Retired count: one per instruction that writes a register or emits OUT
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      retired_cnt <= '0;
    else if (wr_en_regf_W || push_ok)
      retired_cnt <= retired_cnt + 16'd1;
  end

endmodule
